regfile_param: RTL and testbench

Parametrised multi-port register file: the next-generation replacement for the fixed 32x32, two-read-port RegisterFile in the microprocessor datapath. It adds:

- configurable data width, depth and read-port count;
- byte-enable writes;
- an optional hardwired-zero register 0;
- optional write-to-read bypass;
- a sequenced synchronous clear engine, so software can wipe the file without asserting the global reset.

It sits between the decode stage (read addresses) and the writeback stage (write port).

---
 rtl/regfile_param_if.sv | 28 ++
 rtl/regfile_param.sv | 114 +++++++++++
 tb/tb_regfile_param.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_param_if.sv
// Register file port bundle: read addresses and data, write port, clear control.
// The master side (decode/writeback) drives addresses and write data.
// The slave side (the register file) returns read data and clear status.
interface regfile_param_if #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRD = 2
);
    logic [NRD*AW-1:0] ra;
    logic [NRD*DW-1:0] rd;
    logic [AW-1:0]     wa;
    logic [DW-1:0]     wd;
    logic              we;
    logic [DW/8-1:0]   wbe;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;

    modport master (
        output ra, wa, wd, we, wbe, clr_req,
        input  rd, clr_busy, clr_done
    );

    modport slave (
        input  ra, wa, wd, we, wbe, clr_req,
        output rd, clr_busy, clr_done
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised multi-port register file with byte-enable writes, an optional
// hardwired-zero entry 0, optional write-to-read forwarding, and a sequenced
// clear engine that wipes one entry per cycle without using the global reset.
module regfile_param #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic          CLK,
    input  logic          reset,
    regfile_param_if.slave bus
);
    localparam int DEPTH = 1 << AW;
    localparam int NB    = DW / 8;

    // Last pointer value, compared against directly so wrap-around never matters.
    localparam logic [AW-1:0] LAST = '1;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } state_t;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ptr;
    state_t        state;
    logic          clr_busy_q;
    logic          clr_done_q;
    logic          wr_ok;

    // A write is accepted only outside a clear, and never lands on a hardwired entry 0.
    assign wr_ok = bus.we && !clr_busy_q && !((ZERO_R0 != 0) && (bus.wa == '0));

    assign bus.clr_busy = clr_busy_q;
    assign bus.clr_done = clr_done_q;

    // Array storage, byte-wise writes, and the clear sequencer share one process since both modify the array.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            state      <= IDLE;
            ptr        <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                for (int j = 0; j < NB; j++) begin
                    if (bus.wbe[j]) begin
                        mem[bus.wa][8*j +: 8] <= bus.wd[8*j +: 8];
                    end
                end
            end

            case (state)
                IDLE: begin
                    clr_done_q <= 1'b0;
                    if (bus.clr_req) begin
                        state      <= CLEAR;
                        ptr        <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem[ptr] <= '0;
                    if (ptr == LAST) begin
                        state      <= DONE;
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    clr_done_q <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    clr_busy_q <= 1'b0;
                    clr_done_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic [DW-1:0] word;

        assign addr = bus.ra[i*AW +: AW];

        // Combinational read with optional same-cycle forwarding of the enabled write bytes.
        always_comb begin
            word = mem[addr];
            if ((BYPASS != 0) && wr_ok && (bus.wa == addr)) begin
                for (int j = 0; j < NB; j++) begin
                    if (bus.wbe[j]) begin
                        word[8*j +: 8] = bus.wd[8*j +: 8];
                    end
                end
            end
            if ((ZERO_R0 != 0) && (addr == '0)) begin
                word = '0;
            end
        end

        assign bus.rd[i*DW +: DW] = word;
    end
endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: two instances (32x32 with zero-r0 and
// forwarding, and 8x16 with four ports, no zero-r0, no forwarding). Stimulus
// enqueues expected values stamped with the cycle; a negedge monitor pops and compares.
module tb_regfile_param;
    logic CLK = 1'b0;
    logic reset;

    always #5 CLK = ~CLK;

    regfile_param_if #(.DW(32), .AW(5), .NRD(2)) busA ();
    regfile_param_if #(.DW(16), .AW(3), .NRD(4)) busB ();

    regfile_param #(.DW(32), .AW(5), .NRD(2), .ZERO_R0(1), .BYPASS(1)) dutA (
        .CLK   (CLK),
        .reset (reset),
        .bus   (busA.slave)
    );

    regfile_param #(.DW(16), .AW(3), .NRD(4), .ZERO_R0(0), .BYPASS(0)) dutB (
        .CLK   (CLK),
        .reset (reset),
        .bus   (busB.slave)
    );

    // sel: 0 A read port, 1 A busy, 2 A done, 3 B read port, 4 B busy, 5 B done
    typedef struct {
        int          cyc;
        int          sel;
        int          idx;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    // Count rising edges so expectations can be stamped with the cycle they belong to.
    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: on each falling edge compare every expectation stamped for this cycle.
    always @(negedge CLK) begin
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.sel)
                0:       act = busA.rd[e.idx*32 +: 32];
                1:       act = {31'b0, busA.clr_busy};
                2:       act = {31'b0, busA.clr_done};
                3:       act = {16'b0, busB.rd[e.idx*16 +: 16]};
                4:       act = {31'b0, busB.clr_busy};
                default: act = {31'b0, busB.clr_done};
            endcase
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.exp, cyc);
            end
        end
    end

    task automatic checkOutput(input int sel, input int idx, input logic [31:0] v, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.sel  = sel;
        e.idx  = idx;
        e.exp  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic [3:0] wbe);
        busA.we  = we;
        busA.wa  = wa;
        busA.wd  = wd;
        busA.wbe = wbe;
    endtask

    task automatic writeA(input int a, input logic [31:0] d, input logic [3:0] be);
        applyStimulus(1'b1, 5'(a), d, be);
        tick();
        busA.we = 1'b0;
    endtask

    task automatic writeB(input int a, input logic [15:0] d, input logic [1:0] be);
        busB.we  = 1'b1;
        busB.wa  = 3'(a);
        busB.wd  = d;
        busB.wbe = be;
        tick();
        busB.we = 1'b0;
    endtask

    task automatic fillA();
        for (int k = 0; k < 32; k++) begin
            writeA(k, 32'(10 * k), 4'hF);
        end
    endtask

    task automatic checkStatusA(input logic busy, input logic done, input string tag);
        checkOutput(1, 0, {31'b0, busy}, {tag, "_busyA"});
        checkOutput(2, 0, {31'b0, done}, {tag, "_doneA"});
    endtask

    initial begin
        reset        = 1'b1;
        busA.ra      = '0;
        busA.clr_req = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'd0, 4'h0);
        busB.ra      = '0;
        busB.wa      = '0;
        busB.wd      = '0;
        busB.we      = 1'b0;
        busB.wbe     = '0;
        busB.clr_req = 1'b0;

        // Reset state on both instances
        tick();
        busA.ra = {5'd4, 5'd3};
        busB.ra = {3'd7, 3'd5, 3'd3, 3'd1};
        checkOutput(0, 0, 32'd0, "rstRd0");
        checkOutput(0, 1, 32'd0, "rstRd1");
        checkStatusA(1'b0, 1'b0, "rst");
        for (int p = 0; p < 4; p++) checkOutput(3, p, 32'd0, $sformatf("rstB_rd%0d", p));
        checkOutput(4, 0, 32'd0, "rstBusyB");
        checkOutput(5, 0, 32'd0, "rstDoneB");
        tick();
        reset = 1'b0;
        tick();

        // Full write then paired reads
        fillA();
        for (int k = 0; k < 31; k++) begin
            busA.ra = {5'(k + 1), 5'(k)};
            checkOutput(0, 0, 32'(10 * k), $sformatf("pair_rd0_k%0d", k));
            checkOutput(0, 1, 32'(10 * (k + 1)), $sformatf("pair_rd1_k%0d", k));
            tick();
        end

        // Entry 0 hardwired to zero, including no forwarding
        applyStimulus(1'b1, 5'd0, 32'h0000_1234, 4'hF);
        busA.ra = {5'd1, 5'd0};
        checkOutput(0, 0, 32'd0, "r0Bypass");
        tick();
        busA.we = 1'b0;
        checkOutput(0, 0, 32'd0, "r0AfterWrite");
        tick();

        // Byte enables with forwarded merge
        writeA(5, 32'h1122_3344, 4'hF);
        applyStimulus(1'b1, 5'd5, 32'hAABB_CCDD, 4'b0101);
        busA.ra = {5'd6, 5'd5};
        checkOutput(0, 0, 32'h11BB_33DD, "beBypass");
        checkOutput(0, 1, 32'd60, "beOther");
        tick();
        busA.we = 1'b0;
        checkOutput(0, 0, 32'h11BB_33DD, "beRead");
        tick();

        // Same-cycle forwarding and a wbe=0 no-op
        applyStimulus(1'b1, 5'd7, 32'hDEAD_BEEF, 4'hF);
        busA.ra = {5'd8, 5'd7};
        checkOutput(0, 0, 32'hDEAD_BEEF, "bypassSame");
        checkOutput(0, 1, 32'd80, "bypassOther");
        tick();
        applyStimulus(1'b1, 5'd7, 32'h0000_0000, 4'h0);
        checkOutput(0, 0, 32'hDEAD_BEEF, "wbe0Bypass");
        tick();
        busA.we = 1'b0;
        checkOutput(0, 0, 32'hDEAD_BEEF, "wbe0After");
        tick();

        // Sequenced clear with a dropped write
        fillA();
        busA.clr_req = 1'b1;
        tick();
        busA.clr_req = 1'b0;
        for (int j = 0; j < 32; j++) begin
            if (j == 1) begin
                applyStimulus(1'b1, 5'd3, 32'h0000_0005, 4'hF);
                busA.ra = {5'd8, 5'd3};
                checkOutput(0, 0, 32'd30, "clrNoBypass");
            end
            if (j == 2) begin
                busA.we = 1'b0;
                checkOutput(0, 0, 32'd30, "clrWriteDropped");
            end
            if (j == 10) begin
                busA.ra = {5'd20, 5'd9};
                checkOutput(0, 0, 32'd0, "clrEntry9");
                checkOutput(0, 1, 32'd200, "clrEntry20");
            end
            checkStatusA(1'b1, 1'b0, $sformatf("clr_j%0d", j));
            tick();
        end
        checkStatusA(1'b0, 1'b1, "clrDone");
        tick();
        checkStatusA(1'b0, 1'b0, "clrIdle");
        for (int k = 0; k < 32; k += 2) begin
            busA.ra = {5'(k + 1), 5'(k)};
            checkOutput(0, 0, 32'd0, $sformatf("cleared_k%0d", k));
            checkOutput(0, 1, 32'd0, $sformatf("cleared_k%0d", k + 1));
            tick();
        end

        // Simultaneous write and clear request, then reset mid-clear
        fillA();
        applyStimulus(1'b1, 5'd31, 32'd77, 4'hF);
        busA.clr_req = 1'b1;
        tick();
        busA.we      = 1'b0;
        busA.clr_req = 1'b0;
        busA.ra      = {5'd31, 5'd0};
        checkOutput(0, 1, 32'd77, "simulWrite");
        for (int j = 0; j < 5; j++) begin
            checkStatusA(1'b1, 1'b0, $sformatf("pre_rst_j%0d", j));
            tick();
        end
        reset   = 1'b1;
        busA.ra = {5'd31, 5'd20};
        checkOutput(0, 0, 32'd0, "midRstRd0");
        checkOutput(0, 1, 32'd0, "midRstRd1");
        checkStatusA(1'b0, 1'b0, "midRst");
        tick();
        reset = 1'b0;
        for (int j = 0; j < 5; j++) begin
            checkStatusA(1'b0, 1'b0, $sformatf("postRst_j%0d", j));
            tick();
        end
        busA.clr_req = 1'b1;
        tick();
        busA.clr_req = 1'b0;
        for (int j = 0; j < 32; j++) begin
            checkStatusA(1'b1, 1'b0, $sformatf("reclr_j%0d", j));
            tick();
        end
        checkStatusA(1'b0, 1'b1, "reclrDone");
        tick();
        checkStatusA(1'b0, 1'b0, "reclrIdle");
        tick();

        // Narrow instance: entry 0 writable, no forwarding, four ports
        busB.ra = '0;
        busB.we = 1'b1; busB.wa = 3'd0; busB.wd = 16'hBEEF; busB.wbe = 2'b11;
        checkOutput(3, 0, 32'd0, "bNoBypass0");
        tick();
        busB.we = 1'b0;
        for (int p = 0; p < 4; p++) checkOutput(3, p, 32'h0000_BEEF, $sformatf("bR0_p%0d", p));
        tick();
        for (int k = 1; k < 8; k++) writeB(k, 16'(16'h1000 + k), 2'b11);
        busB.ra = {3'd7, 3'd5, 3'd3, 3'd0};
        checkOutput(3, 0, 32'h0000_BEEF, "bMix0");
        checkOutput(3, 1, 32'h0000_1003, "bMix1");
        checkOutput(3, 2, 32'h0000_1005, "bMix2");
        checkOutput(3, 3, 32'h0000_1007, "bMix3");
        tick();
        busB.ra = {3'd2, 3'd1, 3'd6, 3'd4};
        checkOutput(3, 0, 32'h0000_1004, "bMixB0");
        checkOutput(3, 1, 32'h0000_1006, "bMixB1");
        checkOutput(3, 2, 32'h0000_1001, "bMixB2");
        checkOutput(3, 3, 32'h0000_1002, "bMixB3");
        tick();
        busB.ra = {3'd7, 3'd7, 3'd7, 3'd7};
        busB.we = 1'b1; busB.wa = 3'd7; busB.wd = 16'hDEAD; busB.wbe = 2'b11;
        checkOutput(3, 0, 32'h0000_1007, "bOldBeforeEdge");
        tick();
        busB.we = 1'b0;
        checkOutput(3, 0, 32'h0000_DEAD, "bNewAfterEdge");
        tick();
        writeB(6, 16'hABCD, 2'b01);
        busB.ra = {3'd6, 3'd6, 3'd6, 3'd6};
        checkOutput(3, 3, 32'h0000_10CD, "bByteEnable");
        tick();

        // Narrow instance clear: eight busy cycles
        busB.clr_req = 1'b1;
        tick();
        busB.clr_req = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (j == 3) begin
                busB.ra = {3'd3, 3'd2, 3'd1, 3'd0};
                checkOutput(3, 0, 32'd0, "bClrP0");
                checkOutput(3, 1, 32'd0, "bClrP1");
                checkOutput(3, 2, 32'd0, "bClrP2");
                checkOutput(3, 3, 32'h0000_1003, "bClrP3");
            end
            checkOutput(4, 0, 32'd1, $sformatf("bBusy_j%0d", j));
            checkOutput(5, 0, 32'd0, $sformatf("bDone_j%0d", j));
            tick();
        end
        checkOutput(4, 0, 32'd0, "bBusyEnd");
        checkOutput(5, 0, 32'd1, "bDonePulse");
        tick();
        checkOutput(5, 0, 32'd0, "bDoneLow");
        busB.ra = {3'd7, 3'd6, 3'd5, 3'd4};
        for (int p = 0; p < 4; p++) checkOutput(3, p, 32'd0, $sformatf("bClearedHi_p%0d", p));
        tick();
        busB.ra = {3'd3, 3'd2, 3'd1, 3'd0};
        for (int p = 0; p < 4; p++) checkOutput(3, p, 32'd0, $sformatf("bClearedLo_p%0d", p));
        tick();
        tick();
        tick();

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboardDrain: got %0d pending expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
